// File: rtl/matrix_dma_master.sv
// Bus master that streams operands A and B from local memory into a matrix slave,
// waits for its interrupt, then copies the results back. Define DMA_TIMEOUT_EN to add a WAIT watchdog.
module matrix_dma_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic [7:0]  src_a_base,
    input  logic [7:0]  src_b_base,
    input  logic [7:0]  dst_base,
    input  logic [4:0]  word_cnt,
    output logic        busy,
    output logic        op_done,
    output logic        op_error,
    output logic        M_req,
    input  logic        M_grant,
    output logic        M_sel,
    output logic        M_wr,
    output logic [4:0]  M_address,
    output logic [31:0] M_dout,
    input  logic [31:0] M_din,
    input  logic        m_interrupt,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  debug_state
);

`ifdef DMA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, REQ, IEN, LOAD_A, LOAD_B, START, WAIT, READ, STORE, CLEAR, DONE
    } state_t;

    state_t      state, state_n;
    logic        ph, ph_n;
    logic [4:0]  idx, idx_n, cnt;
    logic [31:0] wait_cnt, wait_n;
    logic        err_q, err_n;
    logic        pend_q;
    logic [31:0] data_q, rd_val;
    logic [7:0]  src_a, src_b, dst;
    logic        last;

    // Handshake: M_req is held from REQ through CLEAR; every bus or memory strobe
    // after REQ is qualified by M_grant in the same cycle, so a withdrawn grant freezes progress.
    assign last        = (idx == cnt - 5'd1);
    assign debug_state = state;
    // Read data is live the cycle after a read strobe, then held in data_q across stalls.
    assign rd_val      = pend_q ? ((state == STORE) ? M_din : mem_rdata) : data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph       <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            src_a    <= '0;
            src_b    <= '0;
            dst      <= '0;
        end else begin
            ph       <= ph_n;
            idx      <= idx_n;
            wait_cnt <= wait_n;
            err_q    <= err_n;
            pend_q   <= mem_rd | (M_sel & ~M_wr);
            data_q   <= rd_val;
            if (state == IDLE && op_start) begin
                src_a <= src_a_base;
                src_b <= src_b_base;
                dst   <= dst_base;
                cnt   <= (word_cnt == 5'd0 || word_cnt > 5'd16) ? 5'd16 : word_cnt;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ph_n      = ph;
        idx_n     = idx;
        wait_n    = wait_cnt;
        err_n     = err_q;
        busy      = 1'b0;
        op_done   = 1'b0;
        op_error  = 1'b0;
        M_req     = 1'b0;
        M_sel     = 1'b0;
        M_wr      = 1'b0;
        M_address = '0;
        M_dout    = '0;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        if (state != IDLE && state != DONE) begin
            busy  = 1'b1;
            M_req = 1'b1;
        end
        case (state)
            IDLE: if (op_start) begin
                state_n = REQ;
                ph_n    = 1'b0;
                idx_n   = '0;
                err_n   = 1'b0;
            end
            REQ: if (M_grant) state_n = IEN;
            IEN: if (M_grant) begin
                M_sel     = 1'b1;
                M_wr      = 1'b1;
                M_address = 5'd2;
                M_dout    = 32'd1;
                state_n   = LOAD_A;
            end
            LOAD_A, LOAD_B: if (M_grant) begin
                if (!ph) begin
                    mem_rd   = 1'b1;
                    mem_addr = ((state == LOAD_A) ? src_a : src_b) + {3'b000, idx};
                    ph_n     = 1'b1;
                end else begin
                    M_sel     = 1'b1;
                    M_wr      = 1'b1;
                    M_address = (state == LOAD_A) ? 5'd0 : 5'd1;
                    M_dout    = rd_val;
                    ph_n      = 1'b0;
                    if (last) begin
                        idx_n   = '0;
                        state_n = (state == LOAD_A) ? LOAD_B : START;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            START: if (M_grant) begin
                M_sel     = 1'b1;
                M_wr      = 1'b1;
                M_address = 5'd3;
                M_dout    = 32'd1;
                wait_n    = '0;
                state_n   = WAIT;
            end
            WAIT: begin
                if (m_interrupt) begin
                    state_n = READ;
                end else if (TO_EN && wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_n = CLEAR;
                    ph_n    = 1'b0;
                    err_n   = 1'b1;
                end else begin
                    wait_n = wait_cnt + 32'd1;
                end
            end
            READ: if (M_grant) begin
                M_sel     = 1'b1;
                M_address = {1'b1, idx[3:0]};
                state_n   = STORE;
            end
            STORE: if (M_grant) begin
                mem_wr    = 1'b1;
                mem_addr  = dst + {3'b000, idx};
                mem_wdata = rd_val;
                if (last) begin
                    idx_n   = '0;
                    ph_n    = 1'b0;
                    state_n = CLEAR;
                end else begin
                    idx_n   = idx + 5'd1;
                    state_n = READ;
                end
            end
            CLEAR: if (M_grant) begin
                M_sel     = 1'b1;
                M_wr      = 1'b1;
                M_address = ph ? 5'd3 : 5'd5;
                M_dout    = ph ? 32'd0 : 32'd1;
                ph_n      = ~ph;
                if (ph) state_n = DONE;
            end
            DONE: begin
                op_done  = 1'b1;
                op_error = TO_EN & err_q;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matrix_dma_master.sv
// Randomized bench for matrix_dma_master: memory and slave responders plus a job-level
// reference model that predicts every bus write, bus read and memory access in order.
module tb_matrix_dma_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic [7:0]  src_a_base, src_b_base, dst_base;
    logic [4:0]  word_cnt;
    logic        busy, op_done, op_error, M_req, M_grant, M_sel, M_wr;
    logic [4:0]  M_address;
    logic [31:0] M_dout, M_din;
    logic        m_interrupt;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  debug_state;

    always #5 clk = ~clk;

    matrix_dma_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .op_start(op_start),
        .src_a_base(src_a_base), .src_b_base(src_b_base), .dst_base(dst_base),
        .word_cnt(word_cnt), .busy(busy), .op_done(op_done), .op_error(op_error),
        .M_req(M_req), .M_grant(M_grant), .M_sel(M_sel), .M_wr(M_wr),
        .M_address(M_address), .M_dout(M_dout), .M_din(M_din),
        .m_interrupt(m_interrupt), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .debug_state(debug_state)
    );

`ifdef DMA_TIMEOUT_EN
    localparam int LONG_IRQ = 10;
`else
    localparam int LONG_IRQ = 20;
`endif

    logic [31:0] mem [256];
    logic [31:0] res [16];
    logic [36:0] exp_bus_q[$];
    logic [4:0]  exp_brd_q[$];
    logic [7:0]  exp_mrd_q[$];
    logic [39:0] exp_mwr_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          irq_delay = 0;
    int          grant_mode = 0;
    int          irq_cnt = 0;
    logic        exp_err = 1'b0;
    bit          b_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Local memory (1-cycle read latency), slave result registers and interrupt source.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] = mem_wdata;
        if (M_sel && !M_wr) M_din <= res[M_address[3:0]];
        if (!reset_n) begin
            irq_cnt = 0;
            m_interrupt <= 1'b0;
        end else begin
            m_interrupt <= 1'b0;
            if (M_sel && M_wr && M_address == 5'd3 && M_dout == 32'd1) begin
                irq_cnt = irq_delay;
            end else if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) m_interrupt <= 1'b1;
            end
        end
    end

    // Arbiter: always granted, randomly withheld, or one 5-cycle gap once B starts.
    initial begin
        int gap;
        gap = 0;
        M_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!b_seen) gap = 0;
            case (grant_mode)
                1: M_grant = ($urandom_range(0, 3) != 0);
                2: if (b_seen && gap < 5) begin M_grant = 1'b0; gap++; end
                   else M_grant = 1'b1;
                default: M_grant = 1'b1;
            endcase
        end
    end

    // Scoreboard: every strobe is matched in order against the predicted queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rd || mem_wr) check("mem_rd_wr_excl", mem_rd & mem_wr, 0);
            if (!M_grant && busy) check("stall_strobes", {M_sel, M_wr, mem_rd, mem_wr}, 0);
            if (M_wr) check("wr_has_sel", M_sel, 1);
            if (M_sel && M_wr) begin
                if (M_address == 5'd1) b_seen = 1'b1;
                check("bus_wr_expected", exp_bus_q.size() != 0, 1);
                if (exp_bus_q.size() != 0) check("bus_wr", {M_address, M_dout}, exp_bus_q.pop_front());
            end
            if (M_sel && !M_wr) begin
                check("bus_rd_expected", exp_brd_q.size() != 0, 1);
                if (exp_brd_q.size() != 0) check("bus_rd_addr", M_address, exp_brd_q.pop_front());
            end
            if (mem_rd) begin
                check("mem_rd_expected", exp_mrd_q.size() != 0, 1);
                if (exp_mrd_q.size() != 0) check("mem_rd_addr", mem_addr, exp_mrd_q.pop_front());
            end
            if (mem_wr) begin
                check("mem_wr_expected", exp_mwr_q.size() != 0, 1);
                if (exp_mwr_q.size() != 0) check("mem_wr", {mem_addr, mem_wdata}, exp_mwr_q.pop_front());
            end
            if (op_done) begin
                done_cnt++;
                check("op_error", op_error, exp_err);
            end
        end
    end

    // Reference model: predicts the whole transaction list of one job from its parameters.
    task automatic plan_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                            input logic [4:0] wc, input int irq_d, input int gmode);
        int n;
        n = (wc == 0 || wc > 16) ? 16 : int'(wc);
        exp_bus_q.delete(); exp_brd_q.delete(); exp_mrd_q.delete(); exp_mwr_q.delete();
        b_seen = 1'b0;
        done_cnt = 0;
        grant_mode = gmode;
        irq_delay = irq_d;
        exp_err = (irq_d == 0);
        for (int i = 0; i < 16; i++) res[i] = $urandom;
        exp_bus_q.push_back({5'd2, 32'd1});
        for (int i = 0; i < n; i++) begin
            exp_mrd_q.push_back(8'(a + i));
            exp_bus_q.push_back({5'd0, mem[8'(a + i)]});
        end
        for (int i = 0; i < n; i++) begin
            exp_mrd_q.push_back(8'(b + i));
            exp_bus_q.push_back({5'd1, mem[8'(b + i)]});
        end
        exp_bus_q.push_back({5'd3, 32'd1});
        if (irq_d != 0) begin
            for (int i = 0; i < n; i++) begin
                exp_brd_q.push_back(5'(16 + i));
                exp_mwr_q.push_back({8'(d + i), res[i]});
            end
        end
        exp_bus_q.push_back({5'd5, 32'd1});
        exp_bus_q.push_back({5'd3, 32'd0});
    endtask

    task automatic start_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                             input logic [4:0] wc);
        @(negedge clk);
        op_start = 1'b1;
        src_a_base = a; src_b_base = b; dst_base = d; word_cnt = wc;
        @(negedge clk);
        op_start = 1'b0;
        src_a_base = 8'($urandom); src_b_base = 8'($urandom);
        dst_base = 8'($urandom); word_cnt = 5'($urandom);
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                           input logic [4:0] wc, input int irq_d, input int gmode, input bit poke);
        int n;
        n = (wc == 0 || wc > 16) ? 16 : int'(wc);
        plan_job(a, b, d, wc, irq_d, gmode);
        start_job(a, b, d, wc);
        if (poke) begin
            repeat (3) @(negedge clk);
            op_start = 1'b1;
            @(negedge clk);
            op_start = 1'b0;
        end
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("bus_wr_left", exp_bus_q.size(), 0);
        check("bus_rd_left", exp_brd_q.size(), 0);
        check("mem_rd_left", exp_mrd_q.size(), 0);
        check("mem_wr_left", exp_mwr_q.size(), 0);
        if (irq_d != 0)
            for (int i = 0; i < n; i++) check("dst_word", mem[8'(d + i)], res[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {busy, op_done, op_error, M_req, M_sel, M_wr, mem_rd, mem_wr}, 0);
        check({tag, "_addr"}, {M_address, mem_addr}, 0);
        check({tag, "_data"}, {M_dout, mem_wdata}, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        op_start = 1'b0;
        src_a_base = '0; src_b_base = '0; dst_base = '0; word_cnt = '0;
        M_din = '0; mem_rdata = '0; m_interrupt = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset");

        run_job(8'd0, 8'd8, 8'h40, 5'd4, LONG_IRQ, 0, 1'b0);
        run_job(8'd254, 8'd100, 8'h80, 5'd4, 5, 0, 1'b0);
        run_job(8'd30, 8'd60, 8'h90, 5'd4, 3, 2, 1'b0);
        run_job(8'd16, 8'd48, 8'hA0, 5'd0, 4, 0, 1'b0);
        run_job(8'd200, 8'd240, 8'd250, 5'd20, 6, 1, 1'b1);

        // Reset while the first result read is on the bus, then a clean job.
        plan_job(8'd10, 8'd20, 8'hC0, 5'd4, 2, 0);
        start_job(8'd10, 8'd20, 8'hC0, 5'd4);
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #2;
            if (M_sel && !M_wr) break;
        end
        check("saw_bus_read", M_sel & ~M_wr, 1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_bus_q.delete(); exp_brd_q.delete(); exp_mrd_q.delete(); exp_mwr_q.delete();
        @(negedge clk);
        check_outputs_zero("after_release");
        run_job(8'd10, 8'd20, 8'hC0, 5'd4, 2, 0, 1'b0);

`ifdef DMA_TIMEOUT_EN
        run_job(8'd70, 8'd90, 8'hD0, 5'd3, 0, 0, 1'b0);
`endif

        for (int j = 0; j < 8; j++)
            run_job(8'($urandom), 8'($urandom), 8'($urandom), 5'($urandom_range(0, 20)),
                    $urandom_range(1, 10), $urandom_range(0, 1), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
